// File: rtl/alu_mc_pkg.sv
// Shared definitions for alu_mc: op encoding, FSM states, signed-overflow helper.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Operands of equal sign producing a result of the other sign.
  function automatic logic sgn_ovf(logic sa, logic sb, logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle between the register file, alu_mc and writeback.
interface alu_mc_if #(parameter int WIDTH = 8) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] alu_out_hi;
  logic             carry_out;
  logic             zero;
  logic             overflow;
  logic             illegal;

  modport slave (
    input  in_valid, a, b, op, carry_in, out_ready,
    output in_ready, out_valid, alu_out, alu_out_hi, carry_out, zero, overflow, illegal
  );

  modport master (
    output in_valid, a, b, op, carry_in, out_ready,
    input  in_ready, out_valid, alu_out, alu_out_hi, carry_out, zero, overflow, illegal
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Sequential shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [WIDTH:0]     psum;

  assign done_o = busy_q && (cnt_q == '0);
  assign prod_o = acc_q;

  // Low half of acc holds the unconsumed multiplier bits; high half accumulates.
  always_comb begin
    psum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (start_i) begin
      acc_d   = {{WIDTH{1'b0}}, b_i};
      mcand_d = a_i;
      cnt_d   = CW'(WIDTH);
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        acc_d = {psum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q - CW'(1);
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU with valid/ready handshakes.
// Define ALU_MUL_EN to build the sequential multiplier; otherwise op 7 reports illegal.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic   clk,
  input logic   reset_L,
  alu_mc_if.slave bus
);
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
  logic               cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d;
  logic               accept, is_mul, load_res, load_mul, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   b_eff, r_lo;
  logic [WIDTH:0]     sum;
  logic               r_cout, r_ovf, r_ill;

  // Gated by reset so in_ready reads 0 while reset is held.
  assign bus.in_ready = reset_L && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef ALU_MUL_EN
  assign is_mul = (bus.op == OP_MUL);
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset_L (reset_L),
    .start_i (accept && is_mul),
    .a_i     (bus.a),
    .b_i     (bus.b),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  // Single-cycle datapath; SUB reuses the adder with b inverted and carry_in as borrow.
  always_comb begin
    b_eff  = (bus.op == OP_SUB) ? ~bus.b : bus.b;
    sum    = {1'b0, bus.a} + {1'b0, b_eff}
           + (WIDTH+1)'((bus.op == OP_SUB) ? !bus.carry_in : bus.carry_in);
    r_lo   = '0;
    r_cout = 1'b0;
    r_ovf  = 1'b0;
    r_ill  = 1'b0;
    case (bus.op)
      OP_AND: r_lo = bus.a & bus.b;
      OP_OR:  r_lo = bus.a | bus.b;
      OP_XOR: r_lo = bus.a ^ bus.b;
      OP_ADD, OP_SUB: begin
        r_lo   = sum[WIDTH-1:0];
        r_cout = sum[WIDTH];
        r_ovf  = sgn_ovf(bus.a[WIDTH-1], b_eff[WIDTH-1], sum[WIDTH-1]);
      end
      OP_SHL: begin
        r_lo   = {bus.a[WIDTH-2:0], 1'b0};
        r_cout = bus.a[WIDTH-1];
      end
      OP_SHR: begin
        r_lo   = {1'b0, bus.a[WIDTH-1:1]};
        r_cout = bus.a[0];
      end
      default: r_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    load_res = 1'b0;
    load_mul = 1'b0;
    if (accept) begin
      if (is_mul) begin
        state_d = BUSY;
      end else begin
        state_d  = DONE;
        load_res = 1'b1;
      end
    end else begin
      case (state_q)
        BUSY: if (mul_done) begin
          state_d  = DONE;
          load_mul = 1'b1;
        end
        DONE: if (bus.out_ready) state_d = IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    lo_d   = lo_q;
    hi_d   = hi_q;
    cout_d = cout_q;
    zero_d = zero_q;
    ovf_d  = ovf_q;
    ill_d  = ill_q;
    if (load_res) begin
      lo_d   = r_lo;
      hi_d   = '0;
      cout_d = r_cout;
      zero_d = (r_lo == '0);
      ovf_d  = r_ovf;
      ill_d  = r_ill;
    end else if (load_mul) begin
      lo_d   = mul_prod[WIDTH-1:0];
      hi_d   = mul_prod[2*WIDTH-1:WIDTH];
      cout_d = |mul_prod[2*WIDTH-1:WIDTH];
      zero_d = (mul_prod == '0);
      ovf_d  = 1'b0;
      ill_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.out_valid  = (state_q == DONE);
  assign bus.alu_out    = lo_q;
  assign bus.alu_out_hi = hi_q;
  assign bus.carry_out  = cout_q;
  assign bus.zero       = zero_q;
  assign bus.overflow   = ovf_q;
  assign bus.illegal    = ill_q;
endmodule
